// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
// Shared constants for the registered ALU control sequencer:
//   - ALU op-class encodings driven by the main control unit
//   - R-type function field encodings
//   - ALU operation codes presented to the ALU (CODE_DEFAULT marks an illegal decode)
//   - FSM state encoding used by alu_control_seq
package alu_ctrl_pkg;

  // ALU op classes from the main control unit
  localparam logic [2:0] OP_R_TYPE = 3'b111;
  localparam logic [2:0] OP_ADDI   = 3'b100;
  localparam logic [2:0] OP_ORI    = 3'b101;
  localparam logic [2:0] OP_LUI    = 3'b110;
  localparam logic [2:0] OP_ANDI   = 3'b011;
  localparam logic [2:0] OP_SLTI   = 3'b010;
  localparam logic [2:0] OP_BRANCH = 3'b001;

  // R-type function field values
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;

  // ALU operation codes
  localparam logic [3:0] CODE_ADD     = 4'b0011;
  localparam logic [3:0] CODE_SUB     = 4'b0001;
  localparam logic [3:0] CODE_OR      = 4'b0111;
  localparam logic [3:0] CODE_AND     = 4'b0100;
  localparam logic [3:0] CODE_NOR     = 4'b0110;
  localparam logic [3:0] CODE_SLT     = 4'b0010;
  localparam logic [3:0] CODE_SLL     = 4'b1011;
  localparam logic [3:0] CODE_SRL     = 4'b1111;
  localparam logic [3:0] CODE_MULT    = 4'b1000;
  localparam logic [3:0] CODE_DIV     = 4'b1010;
  localparam logic [3:0] CODE_LUI     = 4'b0101;
  localparam logic [3:0] CODE_DEFAULT = 4'b1001;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_MULTI = 2'd2
  } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode
// Pure combinational lookup of {alu_op, funct} into the ALU operation code.
// Ports:
//   alu_op     in   op class from the main control unit
//   funct      in   instruction function field
//   code       out  ALU operation code (CODE_DEFAULT when nothing matches)
//   is_multi   out  MULT/DIV, handled by the multi-cycle unit
//   use_shamt  out  SLL/SRL: ALU takes the shift amount instead of rs
//   illegal    out  decode fell through to the default code
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int ALU_OP_WIDTH = 3,
  parameter int FUNCT_WIDTH  = 6,
  parameter int CTRL_WIDTH   = 4
) (
  input  logic [ALU_OP_WIDTH-1:0] alu_op,
  input  logic [FUNCT_WIDTH-1:0]  funct,
  output logic [CTRL_WIDTH-1:0]   code,
  output logic                    is_multi,
  output logic                    use_shamt,
  output logic                    illegal
);

  always_comb begin
    code      = CTRL_WIDTH'(CODE_DEFAULT);
    is_multi  = 1'b0;
    use_shamt = 1'b0;
    illegal   = 1'b0;
    case (alu_op)
      ALU_OP_WIDTH'(OP_R_TYPE): begin
        case (funct)
          FUNCT_WIDTH'(FN_ADD):  code = CTRL_WIDTH'(CODE_ADD);
          FUNCT_WIDTH'(FN_SUB):  code = CTRL_WIDTH'(CODE_SUB);
          FUNCT_WIDTH'(FN_OR):   code = CTRL_WIDTH'(CODE_OR);
          FUNCT_WIDTH'(FN_AND):  code = CTRL_WIDTH'(CODE_AND);
          FUNCT_WIDTH'(FN_NOR):  code = CTRL_WIDTH'(CODE_NOR);
          FUNCT_WIDTH'(FN_SLT):  code = CTRL_WIDTH'(CODE_SLT);
          FUNCT_WIDTH'(FN_SLL): begin
            code      = CTRL_WIDTH'(CODE_SLL);
            use_shamt = 1'b1;
          end
          FUNCT_WIDTH'(FN_SRL): begin
            code      = CTRL_WIDTH'(CODE_SRL);
            use_shamt = 1'b1;
          end
          FUNCT_WIDTH'(FN_MULT): begin
            code     = CTRL_WIDTH'(CODE_MULT);
            is_multi = 1'b1;
          end
          FUNCT_WIDTH'(FN_DIV): begin
            code     = CTRL_WIDTH'(CODE_DIV);
            is_multi = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      ALU_OP_WIDTH'(OP_ADDI):   code = CTRL_WIDTH'(CODE_ADD);
      ALU_OP_WIDTH'(OP_ORI):    code = CTRL_WIDTH'(CODE_OR);
      ALU_OP_WIDTH'(OP_LUI):    code = CTRL_WIDTH'(CODE_LUI);
      ALU_OP_WIDTH'(OP_ANDI):   code = CTRL_WIDTH'(CODE_AND);
      ALU_OP_WIDTH'(OP_SLTI):   code = CTRL_WIDTH'(CODE_SLT);
      ALU_OP_WIDTH'(OP_BRANCH): code = CTRL_WIDTH'(CODE_SUB);
      default:                  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_control_seq.sv
// alu_control_seq
// Registered ALU control decoder with a valid/ready handshake. Single-cycle
// ops appear one cycle after acceptance; MULT/DIV hold the issuing stage off
// for their full latency while a down-counter runs.
//
// state | meaning
// IDLE  | no operation held, ready to accept
// HOLD  | result valid on the outputs, waiting for out_ready_i
// MULTI | MULT/DIV in the execute unit, counter running down
//
// Ports:
//   clk, reset           clock (rising edge), async active-high reset
//   flush_i              synchronous flush, beats every other event
//   in_valid_i/in_ready_o    upstream handshake
//   alu_op_i, alu_function_i decode inputs
//   out_valid_o/out_ready_i  downstream handshake
//   alu_operation_o, use_shamt_o, illegal_o  registered decode results
//   busy_o               multi-cycle operation in progress
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int ALU_OP_WIDTH = 3,
  parameter int FUNCT_WIDTH  = 6,
  parameter int CTRL_WIDTH   = 4,
  parameter int MULT_LATENCY = 4,
  parameter int DIV_LATENCY  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [ALU_OP_WIDTH-1:0] alu_op_i,
  input  logic [FUNCT_WIDTH-1:0]  alu_function_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [CTRL_WIDTH-1:0]   alu_operation_o,
  output logic                    use_shamt_o,
  output logic                    illegal_o,
  output logic                    busy_o
);

  localparam int CNT_W = 6;

  state_t                state;
  logic [CNT_W-1:0]      count;
  logic [CTRL_WIDTH-1:0] dec_code;
  logic                  dec_multi;
  logic                  dec_shamt;
  logic                  dec_illegal;
  logic                  accept;
  logic [CNT_W-1:0]      multi_load;

  alu_ctrl_decode #(
    .ALU_OP_WIDTH(ALU_OP_WIDTH),
    .FUNCT_WIDTH (FUNCT_WIDTH),
    .CTRL_WIDTH  (CTRL_WIDTH)
  ) u_decode (
    .alu_op   (alu_op_i),
    .funct    (alu_function_i),
    .code     (dec_code),
    .is_multi (dec_multi),
    .use_shamt(dec_shamt),
    .illegal  (dec_illegal)
  );

  // Depends only on state and the flush/out_ready inputs, never on in_valid_i.
  assign in_ready_o = !flush_i &&
                      (state == ST_IDLE || (state == ST_HOLD && out_ready_i));
  assign accept     = in_valid_i && in_ready_o;

  // The accept cycle and the HOLD transition cycle each count as one cycle of
  // latency, so the counter covers the remaining LATENCY-2.
  assign multi_load = (dec_code == CTRL_WIDTH'(CODE_DIV)) ? CNT_W'(DIV_LATENCY - 2)
                                                          : CNT_W'(MULT_LATENCY - 2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      count           <= '0;
      out_valid_o     <= 1'b0;
      busy_o          <= 1'b0;
      alu_operation_o <= CTRL_WIDTH'(CODE_DEFAULT);
      use_shamt_o     <= 1'b0;
      illegal_o       <= 1'b0;
    end else if (flush_i) begin
      // Data registers keep their contents; out_valid_o already disqualifies them.
      state       <= ST_IDLE;
      count       <= '0;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else if (accept) begin
      alu_operation_o <= dec_code;
      use_shamt_o     <= dec_shamt;
      illegal_o       <= dec_illegal;
      if (dec_multi) begin
        state       <= ST_MULTI;
        count       <= multi_load;
        busy_o      <= 1'b1;
        out_valid_o <= 1'b0;
      end else begin
        state       <= ST_HOLD;
        out_valid_o <= 1'b1;
      end
    end else begin
      case (state)
        ST_HOLD: begin
          if (out_ready_i) begin
            state       <= ST_IDLE;
            out_valid_o <= 1'b0;
          end
        end
        ST_MULTI: begin
          if (count == '0) begin
            state       <= ST_HOLD;
            busy_o      <= 1'b0;
            out_valid_o <= 1'b1;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_seq.sv
module tb_alu_control_seq;

  localparam int MULT_LAT = 4;
  localparam int DIV_LAT  = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush_i;
  logic       in_valid_i;
  logic       out_ready_i;
  logic [2:0] alu_op_i;
  logic [5:0] alu_function_i;
  logic       in_ready_o;
  logic       out_valid_o;
  logic [3:0] alu_operation_o;
  logic       use_shamt_o;
  logic       illegal_o;
  logic       busy_o;

  alu_control_seq #(
    .ALU_OP_WIDTH(3),
    .FUNCT_WIDTH (6),
    .CTRL_WIDTH  (4),
    .MULT_LATENCY(MULT_LAT),
    .DIV_LATENCY (DIV_LAT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .flush_i        (flush_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .alu_op_i       (alu_op_i),
    .alu_function_i (alu_function_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .alu_operation_o(alu_operation_o),
    .use_shamt_o    (use_shamt_o),
    .illegal_o      (illegal_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] code;
    logic       shamt;
    logic       ill;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t popped;
  bit   chk_en = 1'b0;

  // Reference model state: one outstanding op, cycles left until it shows.
  bit   m_pend;
  int   m_rem;
  exp_t m_last;
  bit   exp_ready, exp_valid, exp_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Decode table as listed for the ALU control; lat is cycles to out_valid.
  function automatic exp_t ref_dec(input logic [2:0] op, input logic [5:0] fn, output int lat);
    exp_t r;
    r.code = 4'b1001; r.shamt = 1'b0; r.ill = 1'b1; lat = 1;
    case (op)
      3'b111: begin
        r.ill = 1'b0;
        case (fn)
          6'h20: r.code = 4'b0011;
          6'h22: r.code = 4'b0001;
          6'h25: r.code = 4'b0111;
          6'h24: r.code = 4'b0100;
          6'h27: r.code = 4'b0110;
          6'h2A: r.code = 4'b0010;
          6'h00: begin r.code = 4'b1011; r.shamt = 1'b1; end
          6'h02: begin r.code = 4'b1111; r.shamt = 1'b1; end
          6'h18: begin r.code = 4'b1000; lat = MULT_LAT; end
          6'h1A: begin r.code = 4'b1010; lat = DIV_LAT; end
          default: r.ill = 1'b1;
        endcase
      end
      3'b100: begin r.code = 4'b0011; r.ill = 1'b0; end
      3'b101: begin r.code = 4'b0111; r.ill = 1'b0; end
      3'b110: begin r.code = 4'b0101; r.ill = 1'b0; end
      3'b011: begin r.code = 4'b0100; r.ill = 1'b0; end
      3'b010: begin r.code = 4'b0010; r.ill = 1'b0; end
      3'b001: begin r.code = 4'b0001; r.ill = 1'b0; end
      default: ;
    endcase
    return r;
  endfunction

  function automatic void compute_exp();
    exp_ready = !flush_i && (!m_pend || (m_rem == 0 && out_ready_i));
    exp_valid = m_pend && (m_rem == 0);
    exp_busy  = m_pend && (m_rem > 0);
  endfunction

  // Advance the model across one rising edge using the inputs just sampled.
  function automatic void model_update();
    int   lat;
    exp_t e;
    bit   acc;
    acc = in_valid_i && exp_ready;
    if (flush_i) begin
      m_pend = 1'b0;
      sb.delete();
    end else begin
      if (m_pend && m_rem > 0) m_rem--;
      else if (m_pend && out_ready_i) m_pend = 1'b0;
      if (acc) begin
        e      = ref_dec(alu_op_i, alu_function_i, lat);
        m_pend = 1'b1;
        m_rem  = lat - 1;
        m_last = e;
        sb.push_back(e);
      end
    end
  endfunction

  task automatic step(input bit v, input logic [2:0] op, input logic [5:0] fn,
                      input bit rdy, input bit fl);
    @(posedge clk);
    model_update();
    #1;
    in_valid_i = v; alu_op_i = op; alu_function_i = fn;
    out_ready_i = rdy; flush_i = fl;
    compute_exp();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 3'b000, 6'h00, rdy, 1'b0);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    reset = 1'b1;
    in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
    alu_op_i = 3'b000; alu_function_i = 6'h00;
    m_pend = 1'b0; m_rem = 0; sb.delete();
    m_last = {4'b1001, 1'b0, 1'b0};
    #1;
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_code", alu_operation_o, 4'b1001);
    chk("rst_shamt_ill", {use_shamt_o, illegal_o}, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    compute_exp();
    chk_en = 1'b1;
  endtask

  // Monitor: compares control outputs against the model every cycle, and
  // pops the scoreboard whenever a result is consumed.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready_o, exp_ready);
      chk("out_valid", out_valid_o, exp_valid);
      chk("busy", busy_o, exp_busy);
      chk("held_data", {alu_operation_o, use_shamt_o, illegal_o}, m_last);
      if (out_valid_o && out_ready_i) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_empty: got output %0h with nothing expected at %0t",
                   alu_operation_o, $time);
        end else begin
          popped = sb.pop_front();
          chk("sb_result", {alu_operation_o, use_shamt_o, illegal_o}, popped);
        end
      end
    end
  end

  logic [5:0] fns [10] = '{6'h20, 6'h22, 6'h25, 6'h24, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h18, 6'h1A};

  initial begin
    logic [2:0] op;
    logic [5:0] fn;

    do_reset();
    idle(2, 1'b1);

    // back-to-back ADD, SUB, SLL
    step(1'b1, 3'b111, 6'h20, 1'b1, 1'b0);
    step(1'b1, 3'b111, 6'h22, 1'b1, 1'b0);
    step(1'b1, 3'b111, 6'h00, 1'b1, 1'b0);
    idle(2, 1'b1);

    // MULT with an ADD waiting behind it
    step(1'b1, 3'b111, 6'h18, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 3'b111, 6'h20, 1'b1, 1'b0);
    idle(2, 1'b1);

    // ORI under backpressure
    step(1'b1, 3'b101, 6'h15, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 3'b111, 6'h22, 1'b0, 1'b0);
    step(1'b0, 3'b000, 6'h00, 1'b1, 1'b0);
    idle(2, 1'b1);

    // flush mid-DIV (counter at 10) with a same-cycle request
    step(1'b1, 3'b111, 6'h1A, 1'b1, 1'b0);
    idle(20, 1'b1);
    step(1'b1, 3'b111, 6'h20, 1'b1, 1'b1);
    idle(3, 1'b1);

    // illegal encodings
    step(1'b1, 3'b111, 6'h3F, 1'b1, 1'b0);
    step(1'b1, 3'b000, 6'h2B, 1'b1, 1'b0);
    idle(2, 1'b1);

    // async reset in the middle of a DIV
    step(1'b1, 3'b111, 6'h1A, 1'b1, 1'b0);
    idle(6, 1'b1);
    do_reset();
    idle(2, 1'b1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
      fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 9)];
      step(1'($urandom_range(0, 1)), op, fn,
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
    end
    idle(40, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
